// File: rtl/reg8file_pkg.sv
// Shared types and defaults for the reg8file register bank.
package reg8file_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 8;

  // Clear sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/reg8file_if.sv
// Bus bundle between the write-back producer / operand-fetch consumer and the
// register bank: write handshake, two read ports and the clear controls.
interface reg8file_if
  import reg8file_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int AW    = $clog2(DEFAULT_DEPTH)
);

  logic             wr_valid;
  logic             wr_ready;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [AW-1:0]    rd_addr_a;
  logic [WIDTH-1:0] rd_data_a;
  logic [AW-1:0]    rd_addr_b;
  logic [WIDTH-1:0] rd_data_b;
  logic             clr_req;
  logic             clr_busy;
  logic             clr_done;

  // Pipeline side: issues writes, read addresses and clear requests.
  modport master (
    output wr_valid, wr_addr, wr_data, rd_addr_a, rd_addr_b, clr_req,
    input  wr_ready, rd_data_a, rd_data_b, clr_busy, clr_done
  );

  // Register bank side.
  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_addr_a, rd_addr_b, clr_req,
    output wr_ready, rd_data_a, rd_data_b, clr_busy, clr_done
  );

endinterface

// File: rtl/reg8file_clr_seq.sv
// Clear sequencer: walks an index over every entry, one per cycle, after a
// clr_req seen in IDLE, then pulses clr_done for one cycle. Write acceptance
// is only allowed while idle.
module reg8file_clr_seq
  import reg8file_pkg::*;
#(
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          clr_we,
  output logic [AW-1:0] clr_idx,
  output logic          wr_ready
);

  state_t        state_reg;
  state_t        state_next;
  logic [AW-1:0] idx_reg;
  logic [AW-1:0] idx_next;

  // State and clear-index registers.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  // Next-state and Moore outputs; clr_req outside IDLE is dropped, not queued.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    clr_busy   = 1'b0;
    clr_done   = 1'b0;
    clr_we     = 1'b0;
    wr_ready   = 1'b0;
    case (state_reg)
      IDLE: begin
        wr_ready = 1'b1;
        if (clr_req) begin
          state_next = CLEAR;
          idx_next   = '0;
        end
      end
      CLEAR: begin
        clr_busy = 1'b1;
        clr_we   = 1'b1;
        // Natural AW-bit wrap brings the index back to 0 on the last entry.
        idx_next = idx_reg + 1'b1;
        if (idx_reg == AW'(DEPTH - 1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        clr_done   = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign clr_idx = idx_reg;

endmodule

// File: rtl/reg8file_bank.sv
// Register bank of DEPTH entries of WIDTH bits with a valid/ready write port,
// two registered read ports (1-cycle latency) and a hardware clear sequencer.
// Optional macro REG8FILE_READ_BYPASS_EN: when defined, a read of the entry
// being written in the same cycle returns the new data (write-first);
// otherwise it returns the old contents (read-first).
module reg8file_bank
  import reg8file_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input logic       clk,
  input logic       clr_n,
  reg8file_if.slave bus
);

  logic                        wr_ready;
  logic                        wr_fire;
  logic                        clr_busy;
  logic                        clr_done;
  logic                        clr_we;
  logic [AW-1:0]               clr_idx;
  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [WIDTH-1:0]            rd_data_a_reg;
  logic [WIDTH-1:0]            rd_data_a_next;
  logic [WIDTH-1:0]            rd_data_b_reg;
  logic [WIDTH-1:0]            rd_data_b_next;

  reg8file_clr_seq #(
    .DEPTH (DEPTH)
  ) u_clr_seq (
    .clk      (clk),
    .clr_n    (clr_n),
    .clr_req  (bus.clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .clr_we   (clr_we),
    .clr_idx  (clr_idx),
    .wr_ready (wr_ready)
  );

  assign wr_fire      = bus.wr_valid & wr_ready;
  assign bus.wr_ready = wr_ready;
  assign bus.clr_busy = clr_busy;
  assign bus.clr_done = clr_done;

  // Storage: one register per entry so the whole array resets at once.
  // Clear and port write never coincide because wr_ready is low while clearing.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [WIDTH-1:0] entry_reg;
    logic             entry_clr;
    logic             entry_wr;

    assign entry_clr = clr_we && (clr_idx == AW'(gi));
    assign entry_wr  = wr_fire && (bus.wr_addr == AW'(gi));

    // Entry update: clear sequencer wins, otherwise an accepted port write.
    always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
        entry_reg <= '0;
      end else if (entry_clr) begin
        entry_reg <= '0;
      end else if (entry_wr) begin
        entry_reg <= bus.wr_data;
      end
    end

    assign mem_q[gi] = entry_reg;
  end

  // Read-port data selection, with optional same-cycle write forwarding.
  always_comb begin
    rd_data_a_next = mem_q[bus.rd_addr_a];
    rd_data_b_next = mem_q[bus.rd_addr_b];
`ifdef REG8FILE_READ_BYPASS_EN
    if (wr_fire && (bus.wr_addr == bus.rd_addr_a)) begin
      rd_data_a_next = bus.wr_data;
    end
    if (wr_fire && (bus.wr_addr == bus.rd_addr_b)) begin
      rd_data_b_next = bus.wr_data;
    end
`endif
  end

  // Read output registers, updated every cycle.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      rd_data_a_reg <= '0;
      rd_data_b_reg <= '0;
    end else begin
      rd_data_a_reg <= rd_data_a_next;
      rd_data_b_reg <= rd_data_b_next;
    end
  end

  assign bus.rd_data_a = rd_data_a_reg;
  assign bus.rd_data_b = rd_data_b_reg;

endmodule

// File: tb/tb_reg8file_bank.sv
// Directed self-checking bench for reg8file_bank.
module tb_reg8file_bank;

  logic clk   = 1'b0;
  logic clr_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  reg8file_if #(.WIDTH(8), .AW(3)) bus ();

  reg8file_bank dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [7:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    step();
    bus.wr_valid = 1'b0;
    $display("write addr=%0d data=%02h", a, d);
  endtask

  task automatic test_reset();
    bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_addr_a = '0; bus.rd_addr_b = '0; bus.clr_req = 1'b0;
    clr_n = 1'b0;
    repeat (2) step();
    checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b expected 1", bus.wr_ready); end
    checks++; if (bus.clr_busy !== 1'b0) begin errors++; $display("FAIL reset_clr_busy: got %b expected 0", bus.clr_busy); end
    checks++; if (bus.clr_done !== 1'b0) begin errors++; $display("FAIL reset_clr_done: got %b expected 0", bus.clr_done); end
    clr_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.rd_addr_a = 3'(i);
      bus.rd_addr_b = 3'(7 - i);
      step();
      checks++; if (bus.rd_data_a !== 8'h00) begin errors++; $display("FAIL reset_rd_a[%0d]: got %02h expected 00", i, bus.rd_data_a); end
      checks++; if (bus.rd_data_b !== 8'h00) begin errors++; $display("FAIL reset_rd_b[%0d]: got %02h expected 00", 7 - i, bus.rd_data_b); end
    end
  endtask

  task automatic test_write();
    bus.rd_addr_a = 3'd0; bus.rd_addr_b = 3'd2;
    do_write(3'd3, 8'h5A);
    bus.rd_addr_a = 3'd3;
    step();
    checks++; if (bus.rd_data_a !== 8'h5A) begin errors++; $display("FAIL write_rd_a3: got %02h expected 5a", bus.rd_data_a); end
    checks++; if (bus.rd_data_b !== 8'h00) begin errors++; $display("FAIL write_rd_b2: got %02h expected 00", bus.rd_data_b); end
    do_write(3'd6, 8'hC3);
    bus.rd_addr_b = 3'd6;
    step();
    checks++; if (bus.rd_data_b !== 8'hC3) begin errors++; $display("FAIL write_rd_b6: got %02h expected c3", bus.rd_data_b); end
    // Data/address without valid must be ignored.
    bus.wr_valid = 1'b0; bus.wr_addr = 3'd3; bus.wr_data = 8'hFF;
    repeat (2) step();
    checks++; if (bus.rd_data_a !== 8'h5A) begin errors++; $display("FAIL write_novalid: got %02h expected 5a", bus.rd_data_a); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_addr  = 3'(i);
      bus.wr_data  = 8'(8'h10 + i);
      step();
      $display("write addr=%0d data=%02h", i, 8'(8'h10 + i));
    end
    bus.wr_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.rd_addr_a = 3'(i);
      bus.rd_addr_b = 3'((i + 1) % 8);
      step();
      checks++; if (bus.rd_data_a !== 8'(8'h10 + i)) begin errors++; $display("FAIL b2b_rd_a[%0d]: got %02h expected %02h", i, bus.rd_data_a, 8'(8'h10 + i)); end
      checks++; if (bus.rd_data_b !== 8'(8'h10 + ((i + 1) % 8))) begin errors++; $display("FAIL b2b_rd_b[%0d]: got %02h expected %02h", (i + 1) % 8, bus.rd_data_b, 8'(8'h10 + ((i + 1) % 8))); end
    end
  endtask

  // Clear sequence timing, partial-clear reads, blocked writes, ignored clr_req.
  task automatic test_clear();
    int busy_cnt = 0;
    int nready_cnt = 0;
    int done_cnt = 0;
    int done_k = -1;
    bus.rd_addr_a = 3'd7;
    bus.rd_addr_b = 3'd0;
    bus.clr_req = 1'b1;
    step();
    bus.clr_req = 1'b0;
    $display("clear request issued");
    for (int k = 0; k < 14; k++) begin
      if (bus.clr_busy === 1'b1) busy_cnt++;
      if (bus.wr_ready !== 1'b1) nready_cnt++;
      if (bus.clr_done === 1'b1) begin done_cnt++; done_k = k; end
      if (k == 5) begin
        checks++; if (bus.rd_data_a !== 8'h17) begin errors++; $display("FAIL clear_partial_a7: got %02h expected 17", bus.rd_data_a); end
        checks++; if (bus.rd_data_b !== 8'h00) begin errors++; $display("FAIL clear_partial_b0: got %02h expected 00", bus.rd_data_b); end
      end
      if (k == 2) bus.clr_req = 1'b1;
      if (k == 3) begin
        bus.clr_req = 1'b0;
        bus.wr_valid = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = 8'hEE;
      end
      if (k == 8) bus.clr_req = 1'b1;
      if (k == 9) begin bus.wr_valid = 1'b0; bus.clr_req = 1'b0; end
      step();
    end
    checks++; if (busy_cnt !== 8) begin errors++; $display("FAIL clear_busy_cycles: got %0d expected 8", busy_cnt); end
    checks++; if (nready_cnt !== 9) begin errors++; $display("FAIL clear_notready_cycles: got %0d expected 9", nready_cnt); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL clear_done_pulses: got %0d expected 1", done_cnt); end
    checks++; if (done_k !== 8) begin errors++; $display("FAIL clear_done_cycle: got %0d expected 8", done_k); end
    for (int i = 0; i < 8; i++) begin
      bus.rd_addr_a = 3'(i);
      bus.rd_addr_b = 3'(7 - i);
      step();
      checks++; if (bus.rd_data_a !== 8'h00) begin errors++; $display("FAIL clear_rd_a[%0d]: got %02h expected 00", i, bus.rd_data_a); end
      checks++; if (bus.rd_data_b !== 8'h00) begin errors++; $display("FAIL clear_rd_b[%0d]: got %02h expected 00", 7 - i, bus.rd_data_b); end
    end
  endtask

  task automatic test_bypass();
    logic [7:0] exp_a;
    logic [7:0] exp_b;
`ifdef REG8FILE_READ_BYPASS_EN
    exp_a = 8'hA5;
    exp_b = 8'h3C;
`else
    exp_a = 8'h11;
    exp_b = 8'h00;
`endif
    do_write(3'd5, 8'h11);
    bus.rd_addr_a = 3'd5;
    bus.rd_addr_b = 3'd4;
    do_write(3'd5, 8'hA5);
    checks++; if (bus.rd_data_a !== exp_a) begin errors++; $display("FAIL bypass_a_same_cycle: got %02h expected %02h", bus.rd_data_a, exp_a); end
    checks++; if (bus.rd_data_b !== 8'h00) begin errors++; $display("FAIL bypass_b_other_addr: got %02h expected 00", bus.rd_data_b); end
    step();
    checks++; if (bus.rd_data_a !== 8'hA5) begin errors++; $display("FAIL bypass_a_next: got %02h expected a5", bus.rd_data_a); end
    do_write(3'd4, 8'h3C);
    checks++; if (bus.rd_data_b !== exp_b) begin errors++; $display("FAIL bypass_b_same_cycle: got %02h expected %02h", bus.rd_data_b, exp_b); end
    checks++; if (bus.rd_data_a !== 8'hA5) begin errors++; $display("FAIL bypass_a_unaffected: got %02h expected a5", bus.rd_data_a); end
    step();
    checks++; if (bus.rd_data_b !== 8'h3C) begin errors++; $display("FAIL bypass_b_next: got %02h expected 3c", bus.rd_data_b); end
  endtask

  // A write firing together with clr_req completes, then gets cleared.
  task automatic test_clr_with_write();
    bus.rd_addr_a = 3'd6;
    bus.wr_valid = 1'b1; bus.wr_addr = 3'd6; bus.wr_data = 8'h66;
    bus.clr_req = 1'b1;
    step();
    bus.wr_valid = 1'b0; bus.clr_req = 1'b0;
    $display("write addr=6 data=66 with clear request");
    checks++; if (bus.clr_busy !== 1'b1) begin errors++; $display("FAIL clrw_busy: got %b expected 1", bus.clr_busy); end
    step();
    checks++; if (bus.rd_data_a !== 8'h66) begin errors++; $display("FAIL clrw_write_landed: got %02h expected 66", bus.rd_data_a); end
    repeat (10) step();
    checks++; if (bus.rd_data_a !== 8'h00) begin errors++; $display("FAIL clrw_overwritten: got %02h expected 00", bus.rd_data_a); end
    checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL clrw_ready: got %b expected 1", bus.wr_ready); end
  endtask

  task automatic test_reset_mid_clear();
    int done_seen = 0;
    int busy_seen = 0;
    do_write(3'd7, 8'h77);
    do_write(3'd2, 8'h22);
    bus.rd_addr_a = 3'd7;
    bus.rd_addr_b = 3'd2;
    step();
    checks++; if (bus.rd_data_a !== 8'h77) begin errors++; $display("FAIL midrst_pre_a: got %02h expected 77", bus.rd_data_a); end
    bus.clr_req = 1'b1;
    step();
    bus.clr_req = 1'b0;
    repeat (3) step();
    checks++; if (bus.clr_busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b expected 1", bus.clr_busy); end
    clr_n = 1'b0;
    $display("reset asserted during clear");
    #1;
    checks++; if (bus.clr_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", bus.clr_busy); end
    checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b expected 1", bus.wr_ready); end
    checks++; if (bus.clr_done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", bus.clr_done); end
    checks++; if (bus.rd_data_a !== 8'h00) begin errors++; $display("FAIL midrst_rd_a: got %02h expected 00", bus.rd_data_a); end
    #2;
    clr_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      if (bus.clr_done === 1'b1) done_seen++;
      if (bus.clr_busy === 1'b1) busy_seen++;
    end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses expected 0", done_seen); end
    checks++; if (busy_seen !== 0) begin errors++; $display("FAIL midrst_no_busy: got %0d cycles expected 0", busy_seen); end
    checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready_after: got %b expected 1", bus.wr_ready); end
    for (int i = 0; i < 8; i++) begin
      bus.rd_addr_a = 3'(i);
      step();
      checks++; if (bus.rd_data_a !== 8'h00) begin errors++; $display("FAIL midrst_rd[%0d]: got %02h expected 00", i, bus.rd_data_a); end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_back_to_back();
    test_clear();
    test_bypass();
    test_clr_with_write();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Bound the run in case the sequence stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
